// File: rtl/multicycle_ctrl_if.sv
// Control-unit bus: instruction/data memory handshakes, ALU flags,
// datapath strobes and status.
interface multicycle_ctrl_if;
   logic [31:0] instr;
   logic        imem_ready;
   logic        dmem_ready;
   logic        zero;
   logic        lt;
   logic [3:0]  ALUCtrl;
   logic        IRWrite;
   logic        ALUSrc;
   logic        MemtoReg;
   logic        MemRead;
   logic        MemWrite;
   logic        RegWrite;
   logic        PCSrc;
   logic        loadPC;
   logic [2:0]  state;
   logic        illegal_instr;
   logic        mem_err;

   modport master (
      output instr, imem_ready, dmem_ready, zero, lt,
      input  ALUCtrl, IRWrite, ALUSrc, MemtoReg, MemRead,
      input  MemWrite, RegWrite, PCSrc, loadPC,
      input  state, illegal_instr, mem_err
   );

   modport slave (
      input  instr, imem_ready, dmem_ready, zero, lt,
      output ALUCtrl, IRWrite, ALUSrc, MemtoReg, MemRead,
      output MemWrite, RegWrite, PCSrc, loadPC,
      output state, illegal_instr, mem_err
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: IF/ID/EX/MEM/WB with sticky
// illegal-instruction and memory-timeout error state.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT       = 15,
   parameter logic [2:0]  INITIAL_STATE_ENC = 3'b000
) (
   input logic              clk,
   input logic              rst,
   multicycle_ctrl_if.slave ctrl
);
   typedef enum logic [2:0] {
      S_IF  = INITIAL_STATE_ENC,
      S_ID  = 3'b001,
      S_EX  = 3'b010,
      S_MEM = 3'b011,
      S_WB  = 3'b100,
      S_ERR = 3'b101
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0100;
   localparam logic [3:0] ALU_XOR = 4'b0101;
   localparam logic [3:0] ALU_LSR = 4'b1000;
   localparam logic [3:0] ALU_LSL = 4'b1001;
   localparam logic [3:0] ALU_ASR = 4'b1010;

   localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [6:0] opcode_q, opcode_d;
   logic [2:0] funct3_q, funct3_d;
   logic [6:0] funct7_q, funct7_d;
   logic [7:0] cnt_q, cnt_d;
   logic       ill_q, ill_d;
   logic       merr_q, merr_d;

   logic       is_load, is_store, is_itype, is_branch, is_rtype;
   logic       dec_ok, taken;
   logic [3:0] dec_alu, alu_sel;
   logic       unused_instr_bits;

   assign unused_instr_bits = ^{ctrl.instr[24:15], ctrl.instr[11:7]};

   assign is_load   = opcode_q == OP_LOAD;
   assign is_store  = opcode_q == OP_STORE;
   assign is_itype  = opcode_q == OP_ITYPE;
   assign is_branch = opcode_q == OP_BRANCH;
   assign is_rtype  = opcode_q == OP_RTYPE;

   always_comb begin
      dec_alu = ALU_ADD;
      dec_ok  = 1'b1;
      unique case (opcode_q)
         OP_LOAD, OP_STORE: dec_alu = ALU_ADD;
         OP_BRANCH: begin
            dec_alu = ALU_SUB;
            dec_ok  = funct3_q inside {3'b000, 3'b001, 3'b100, 3'b101};
         end
         OP_RTYPE, OP_ITYPE: begin
            unique case (funct3_q)
               3'b000: begin
                  if (!is_rtype || funct7_q == F7_BASE) dec_alu = ALU_ADD;
                  else if (funct7_q == F7_ALT) dec_alu = ALU_SUB;
                  else dec_ok = 1'b0;
               end
               3'b001: dec_alu = ALU_LSL;
               3'b010: dec_alu = ALU_SLT;
               3'b011: dec_ok  = !is_rtype;
               3'b100: dec_alu = ALU_XOR;
               3'b101: begin
                  if (funct7_q == F7_BASE) dec_alu = ALU_LSR;
                  else if (funct7_q == F7_ALT) dec_alu = ALU_ASR;
                  else dec_ok = 1'b0;
               end
               3'b110: dec_alu = ALU_OR;
               3'b111: dec_alu = ALU_AND;
            endcase
         end
         default: dec_ok = 1'b0;
      endcase
   end

   // undecodable instructions park the ALU on ADD while heading to ERR
   assign alu_sel = dec_ok ? dec_alu : ALU_ADD;

   always_comb begin
      case (funct3_q)
         3'b000:  taken = ctrl.zero;
         3'b001:  taken = !ctrl.zero;
         3'b100:  taken = ctrl.lt;
         default: taken = !ctrl.lt;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      opcode_d      = opcode_q;
      funct3_d      = funct3_q;
      funct7_d      = funct7_q;
      cnt_d         = '0;
      ill_d         = ill_q;
      merr_d        = merr_q;
      ctrl.ALUCtrl  = ALU_ADD;
      ctrl.IRWrite  = 1'b0;
      ctrl.ALUSrc   = 1'b0;
      ctrl.MemtoReg = 1'b0;
      ctrl.MemRead  = 1'b0;
      ctrl.MemWrite = 1'b0;
      ctrl.RegWrite = 1'b0;
      ctrl.PCSrc    = 1'b0;
      ctrl.loadPC   = 1'b0;
      unique case (state_q)
         S_IF: begin
            if (ctrl.imem_ready) begin
               ctrl.IRWrite = !rst;
               opcode_d     = ctrl.instr[6:0];
               funct3_d     = ctrl.instr[14:12];
               funct7_d     = ctrl.instr[31:25];
               state_d      = S_ID;
            end
         end
         S_ID: begin
            ctrl.ALUCtrl = alu_sel;
            if (dec_ok) begin
               state_d = S_EX;
            end else begin
               state_d = S_ERR;
               ill_d   = 1'b1;
            end
         end
         S_EX: begin
            ctrl.ALUCtrl = alu_sel;
            ctrl.ALUSrc  = is_load | is_store | is_itype;
            state_d      = (is_load | is_store) ? S_MEM : S_WB;
         end
         S_MEM: begin
            ctrl.ALUCtrl  = alu_sel;
            ctrl.ALUSrc   = 1'b1;
            ctrl.MemRead  = is_load;
            ctrl.MemWrite = is_store;
            if (ctrl.dmem_ready) begin
               state_d = S_WB;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_ERR;
               merr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WB: begin
            ctrl.ALUCtrl  = alu_sel;
            ctrl.ALUSrc   = is_load | is_store | is_itype;
            ctrl.loadPC   = 1'b1;
            ctrl.RegWrite = is_load | is_rtype | is_itype;
            ctrl.MemtoReg = is_load;
            ctrl.PCSrc    = is_branch & taken;
            state_d       = S_IF;
         end
         S_ERR: state_d = S_ERR;
         default: state_d = S_IF;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IF;
         opcode_q <= '0;
         funct3_q <= '0;
         funct7_q <= '0;
         cnt_q    <= '0;
         ill_q    <= 1'b0;
         merr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         funct3_q <= funct3_d;
         funct7_q <= funct7_d;
         cnt_q    <= cnt_d;
         ill_q    <= ill_d;
         merr_q   <= merr_d;
      end
   end

   assign ctrl.state         = state_q;
   assign ctrl.illegal_instr = ill_q;
   assign ctrl.mem_err       = merr_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: decode table, directed corner cases and
// random instruction streams against a per-instruction reference model.
module tb_multicycle_ctrl;
   localparam int TO = 15;
   localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3, S_WB = 3'd4, S_ERR = 3'd5;
   localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001;
   localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110;
   localparam logic [3:0] A_SLT = 4'b0100, A_XOR = 4'b0101;
   localparam logic [3:0] A_LSR = 4'b1000, A_LSL = 4'b1001;
   localparam logic [3:0] A_ASR = 4'b1010;
   localparam logic [31:0] I_SW = 32'h0030A023;

   typedef struct {
      logic [31:0] ins;
      logic [3:0]  alu;
      bit          ill;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   fails = 0;
   vec_t tbl[$];

   multicycle_ctrl_if bus();

   multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk  (clk),
      .rst  (rst),
      .ctrl (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] act();
      return {bus.state, bus.ALUCtrl, bus.IRWrite, bus.ALUSrc,
              bus.MemtoReg, bus.MemRead, bus.MemWrite, bus.RegWrite,
              bus.PCSrc, bus.loadPC, bus.illegal_instr, bus.mem_err};
   endfunction

   // f = {IRWrite,ALUSrc,MemtoReg,MemRead,MemWrite,RegWrite,PCSrc,loadPC,ill,merr}
   function automatic logic [16:0] ev(logic [2:0] st, logic [3:0] alu,
                                      logic [9:0] f);
      return {st, alu, f};
   endfunction

   task automatic chk(input string nm, input logic [16:0] e);
      checks++;
      if (act() !== e) begin
         fails++;
         $display("FAIL %s act=%h exp=%h", nm, act(), e);
      end
   endtask

   // kind: 0 load, 1 store, 2 I-type, 3 branch, 4 R-type, 5 unknown
   function automatic void ref_dec(input logic [31:0] ins, output bit ok,
                                   output logic [3:0] alu, output int kind);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [3:0] by_f3 [8];
      by_f3 = '{A_ADD, A_LSL, A_SLT, A_ADD, A_XOR, A_LSR, A_OR, A_AND};
      op = ins[6:0];
      f3 = ins[14:12];
      f7 = ins[31:25];
      ok = 1;
      alu = A_ADD;
      kind = 5;
      if (op == 7'h03) kind = 0;
      else if (op == 7'h23) kind = 1;
      else if (op == 7'h13) kind = 2;
      else if (op == 7'h63) kind = 3;
      else if (op == 7'h33) kind = 4;
      else ok = 0;
      if (kind == 3) begin
         alu = A_SUB;
         ok = (f3 == 0) || (f3 == 1) || (f3 == 4) || (f3 == 5);
      end
      if (kind == 2 || kind == 4) begin
         alu = by_f3[f3];
         if (kind == 4 && f3 == 3) ok = 0;
         if (kind == 4 && f3 == 0) begin
            if (f7 == 7'h20) alu = A_SUB;
            else if (f7 != 0) ok = 0;
         end
         if (f3 == 5) begin
            if (f7 == 7'h20) alu = A_ASR;
            else if (f7 != 0) ok = 0;
         end
      end
      if (!ok) alu = A_ADD;
   endfunction

   function automatic bit ref_taken(logic [2:0] f3, logic z, logic l);
      if (f3 == 0) return z;
      if (f3 == 1) return !z;
      if (f3 == 4) return l;
      return !l;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.imem_ready = 1'b1;
      bus.dmem_ready = 1'b1;
      @(negedge clk);
      chk("reset", ev(S_IF, A_ADD, 10'b0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
   endtask

   task automatic run_instr(input logic [31:0] ins, input int idly,
                            input int ddly, input logic z, input logic l,
                            output logic [3:0] id_alu, output logic ill_seen);
      bit ok;
      logic [3:0] alu;
      int kind;
      logic asrc, ld, st, rw, pcs;
      ref_dec(ins, ok, alu, kind);
      ld = (kind == 0);
      st = (kind == 1);
      asrc = (kind <= 2);
      rw = (kind == 0) || (kind == 2) || (kind == 4);
      pcs = (kind == 3) && ref_taken(ins[14:12], z, l);
      for (int i = 0; i < idly; i++) begin
         bus.imem_ready = 1'b0;
         bus.instr = $urandom;
         @(negedge clk);
         chk("if_wait", ev(S_IF, A_ADD, 10'b0));
         @(posedge clk);
         #1;
      end
      bus.imem_ready = 1'b1;
      bus.instr = ins;
      @(negedge clk);
      chk("if_fetch", ev(S_IF, A_ADD, 10'b1000000000));
      @(posedge clk);
      #1;
      bus.imem_ready = 1'b0;
      bus.instr = $urandom;
      @(negedge clk);
      id_alu = bus.ALUCtrl;
      chk("id", ev(S_ID, alu, 10'b0));
      @(posedge clk);
      #1;
      bus.instr = $urandom;
      @(negedge clk);
      ill_seen = bus.illegal_instr;
      if (!ok) begin
         chk("ill_err", ev(S_ERR, A_ADD, 10'b0000000010));
         @(posedge clk);
         #1;
         bus.imem_ready = 1'b1;
         bus.dmem_ready = 1'b1;
         @(negedge clk);
         chk("ill_hold", ev(S_ERR, A_ADD, 10'b0000000010));
         @(posedge clk);
         #1;
         do_reset();
         return;
      end
      chk("ex", ev(S_EX, alu, {1'b0, asrc, 8'b0}));
      @(posedge clk);
      #1;
      if (ld || st) begin
         for (int k = 0; k < TO; k++) begin
            bus.dmem_ready = (k == ddly);
            @(negedge clk);
            chk("mem", ev(S_MEM, alu, {2'b01, 1'b0, ld, st, 5'b0}));
            @(posedge clk);
            #1;
            if (k == ddly) break;
         end
         bus.dmem_ready = 1'b0;
         if (ddly >= TO) begin
            @(negedge clk);
            chk("mem_err", ev(S_ERR, A_ADD, 10'b0000000001));
            @(posedge clk);
            #1;
            bus.dmem_ready = 1'b1;
            @(negedge clk);
            chk("merr_hold", ev(S_ERR, A_ADD, 10'b0000000001));
            @(posedge clk);
            #1;
            do_reset();
            return;
         end
      end
      bus.zero = z;
      bus.lt = l;
      @(negedge clk);
      chk("wb", ev(S_WB, alu, {1'b0, asrc, ld, 2'b00, rw, pcs, 1'b1, 2'b00}));
      @(posedge clk);
      #1;
      bus.zero = $urandom;
      bus.lt = $urandom;
   endtask

   initial begin
      logic [3:0] a;
      logic il;
      logic [6:0] ops [5];
      logic [6:0] op, f7;
      int dd;
      ops = '{7'h03, 7'h13, 7'h23, 7'h63, 7'h33};
      bus.instr = '0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      bus.zero = 1'b0;
      bus.lt = 1'b0;

      tbl.push_back('{32'h002081B3, A_ADD, 1'b0});
      tbl.push_back('{32'h402081B3, A_SUB, 1'b0});
      tbl.push_back('{32'h0020F1B3, A_AND, 1'b0});
      tbl.push_back('{32'h0020E1B3, A_OR,  1'b0});
      tbl.push_back('{32'h002091B3, A_LSL, 1'b0});
      tbl.push_back('{32'h0020D1B3, A_LSR, 1'b0});
      tbl.push_back('{32'h4020D1B3, A_ASR, 1'b0});
      tbl.push_back('{32'h0020A1B3, A_SLT, 1'b0});
      tbl.push_back('{32'h0020C1B3, A_XOR, 1'b0});
      tbl.push_back('{32'h0020B1B3, A_ADD, 1'b1});
      tbl.push_back('{32'h022081B3, A_ADD, 1'b1});
      tbl.push_back('{32'h0000A183, A_ADD, 1'b0});
      tbl.push_back('{I_SW,         A_ADD, 1'b0});
      tbl.push_back('{32'h00108093, A_ADD, 1'b0});
      tbl.push_back('{32'h4010D093, A_ASR, 1'b0});
      tbl.push_back('{32'h0210D093, A_ADD, 1'b1});
      tbl.push_back('{32'h00209463, A_SUB, 1'b0});
      tbl.push_back('{32'h0020A463, A_ADD, 1'b1});
      tbl.push_back('{32'h0000007F, A_ADD, 1'b1});

      do_reset();

      foreach (tbl[i]) begin
         run_instr(tbl[i].ins, 1, 1, 1'b0, 1'b0, a, il);
         checks++;
         if (il !== tbl[i].ill) begin
            fails++;
            $display("FAIL tbl_ill[%0d] act=%b exp=%b", i, il, tbl[i].ill);
         end
         if (!tbl[i].ill) begin
            checks++;
            if (a !== tbl[i].alu) begin
               fails++;
               $display("FAIL tbl_alu[%0d] act=%b exp=%b", i, a, tbl[i].alu);
            end
         end
      end

      run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, a, il);
      run_instr(32'h0000A183, 2, 3, 1'b0, 1'b0, a, il);
      run_instr(I_SW, 0, 14, 1'b0, 1'b0, a, il);
      run_instr(I_SW, 0, 99, 1'b0, 1'b0, a, il);
      run_instr(32'h0000A183, 0, 99, 1'b0, 1'b0, a, il);
      run_instr(32'h00209463, 0, 0, 1'b0, 1'b0, a, il);
      run_instr(32'h00209463, 0, 0, 1'b1, 1'b0, a, il);
      run_instr(32'h0020C463, 0, 0, 1'b0, 1'b1, a, il);
      run_instr(32'h0020D463, 0, 0, 1'b0, 1'b1, a, il);

      bus.imem_ready = 1'b1;
      bus.instr = I_SW;
      @(posedge clk);
      #1;
      bus.imem_ready = 1'b0;
      bus.instr = $urandom;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("mem_pre_rst", ev(S_MEM, A_ADD, 10'b0100100000));
      #2;
      rst = 1'b1;
      #1;
      chk("rst_abort", ev(S_IF, A_ADD, 10'b0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_abort", ev(S_IF, A_ADD, 10'b0));
      @(posedge clk);
      #1;

      for (int n = 0; n < 60; n++) begin
         op = ($urandom_range(0, 5) == 0) ? 7'($urandom) : ops[$urandom_range(0, 4)];
         case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = 7'($urandom);
         endcase
         dd = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5);
         run_instr({f7, 10'($urandom), 3'($urandom), 5'($urandom), op},
                   $urandom_range(0, 3), dd, 1'($urandom), 1'($urandom),
                   a, il);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
